// File: rtl/alu_iter.sv
// alu_iter -- iterative ALU with a multi-cycle barrel-free shifter.
//
// Add/sub/logic/compare/pass operations complete one cycle after acceptance.
// Shifts walk the registered result SHIFT_STEP bit positions per cycle, so a
// shift takes 1 + ceil(shamt / SHIFT_STEP) cycles from accept to out_valid.
//
// Parameters
//   XLEN        operand/result width (power of two, 8..64)
//   SHIFT_STEP  max bit positions shifted per cycle (power of two, 1..XLEN)
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   request valid
//   in_ready   request accepted when in_valid & in_ready at a rising edge
//   op         0 add, 1 sll, 2 srl, 3 sra, 4 pass, 5 and, 6 or, 7 xor,
//              8 sub, 9 slt, 10 sltu, 11-15 reserved (return 0)
//   a          first operand / shift source
//   b          second operand / pass value / shift amount source
//   out_valid  result valid
//   out_ready  consumer ready; result consumed on out_valid & out_ready
//   result     registered result
//   busy       high while a shift is in progress

module alu_iter #(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int SHW = $clog2(XLEN);

   // SHIFT_STEP may equal XLEN, which needs one bit more than a shift amount.
   localparam logic [SHW:0] STEP_W = SHIFT_STEP[SHW:0];

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SLL  = 4'd1;
   localparam logic [3:0] OP_SRL  = 4'd2;
   localparam logic [3:0] OP_SRA  = 4'd3;
   localparam logic [3:0] OP_PASS = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_OR   = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_SUB  = 4'd8;
   localparam logic [3:0] OP_SLT  = 4'd9;
   localparam logic [3:0] OP_SLTU = 4'd10;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t          state;
   logic [SHW-1:0]  remaining;
   logic [1:0]      shift_op;

   logic            accept;
   logic            is_shift;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] alu_res;
   logic [SHW:0]    rem_ext;
   logic [SHW:0]    k;
   logic [SHW-1:0]  rem_next;
   logic [XLEN-1:0] shifted;

   // Handshake and status decode straight from the registered state; in_ready
   // is forced low during reset so nothing is accepted on a reset edge.
   assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
   assign out_valid = (state == DONE);
   assign busy      = (state == SHIFT);
   assign accept    = in_valid && in_ready;

   assign shamt    = b[SHW-1:0];
   assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

   // Single-cycle result for every op. A shift only lands here when its
   // amount is zero, in which case the answer is simply a.
   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:  alu_res = a + b;
         OP_SLL,
         OP_SRL,
         OP_SRA:  alu_res = a;
         OP_PASS: alu_res = b;
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_SUB:  alu_res = a - b;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
         default: alu_res = '0;
      endcase
   end

   // One shift step: move by min(SHIFT_STEP, remaining). An arithmetic shift
   // of the partial result keeps re-using the sign bit of the original a,
   // because every earlier step has already replicated it into the MSB.
   always_comb begin
      rem_ext  = {1'b0, remaining};
      k        = (rem_ext > STEP_W) ? STEP_W : rem_ext;
      rem_next = remaining - k[SHW-1:0];
      case (shift_op)
         2'd1:    shifted = result << k;
         2'd2:    shifted = result >> k;
         default: shifted = $signed(result) >>> k;
      endcase
   end

   // Control FSM and datapath registers. Operands are captured only on the
   // accept edge; a DONE that is consumed together with a new request goes
   // straight into the next operation, giving one result per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         result    <= '0;
         remaining <= '0;
         shift_op  <= '0;
      end else if (accept) begin
         if (is_shift && (shamt != '0)) begin
            result    <= a;
            remaining <= shamt;
            shift_op  <= op[1:0];
            state     <= SHIFT;
         end else begin
            result <= alu_res;
            state  <= DONE;
         end
      end else begin
         case (state)
            SHIFT: begin
               result    <= shifted;
               remaining <= rem_next;
               if (rem_next == '0) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
